blit_data_loader: RTL

Blitter read-data capture stage. It registers 64-bit phrases returned from the memory bus into the source, destination and pattern operand registers that feed the blitter adder-A data multiplexer. It also produces the bit-aligned source phrase from two consecutive raw source reads. It sits between the bus read-data path and the data mux / adder pipeline, and tracks source-pipeline fill state with a small FSM.

---
 rtl/blit_data_loader_pkg.sv | 13 +
 rtl/blit_phrase_reg.sv | 29 ++
 rtl/blit_data_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/blit_data_loader_pkg.sv
// Shared blitter definitions: source-pipeline states and phrase/shift widths.
package blit_data_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FIRST = 2'd1,
    READY = 2'd2
  } src_state_t;

  localparam int PHRASE_W = 64;
  localparam int SHIFT_W  = 6;

endpackage

// File: rtl/blit_phrase_reg.sv
// Phrase register with load enable and synchronous clear; a load wins over a clear
// so that a flush and a load in the same cycle leave the new phrase in place.
import blit_data_loader_pkg::*;

module blit_phrase_reg #(
  parameter int W = PHRASE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // phrase storage
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/blit_data_loader.sv
// Blitter read-data capture: operand registers plus the bit-aligned source phrase
// built from the last two raw source reads.
import blit_data_loader_pkg::*;

module blit_data_loader #(
  parameter int PW = 32
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic [PW-1:0] data_0,
  input  logic [PW-1:0] data_1,
  input  logic          ld_src,
  input  logic          ld_dst,
  input  logic          ld_pat,
  input  logic          ld_srcz1,
  input  logic          ld_srcz2,
  input  logic          src_flush,
  input  logic [5:0]    srcshift,
  output logic [PW-1:0] srcd_0,
  output logic [PW-1:0] srcd_1,
  output logic          srcd_valid,
  output logic [PW-1:0] dstd_0,
  output logic [PW-1:0] dstd_1,
  output logic [PW-1:0] patd_0,
  output logic [PW-1:0] patd_1,
  output logic [PW-1:0] srcz1_0,
  output logic [PW-1:0] srcz1_1,
  output logic [PW-1:0] srcz2_0,
  output logic [PW-1:0] srcz2_1
);

  src_state_t          st, st_next;
  logic [5:0]          shreg, shreg_next;
  logic [2*PW-1:0]     data, cur, prev, prev_d;
  logic [2*PW-1:0]     dst, pat, srcz1, srcz2;
  logic [4*PW-1:0]     wide;
  logic                eff_empty;

  assign data = {data_1, data_0};

  // state and captured shift
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      st    <= EMPTY;
      shreg <= 6'd0;
    end else begin
      st    <= st_next;
      shreg <= shreg_next;
    end
  end

  // a flush with a load behaves as a load into an empty pipeline
  always_comb begin
    st_next    = st;
    shreg_next = shreg;
    eff_empty  = src_flush || (st == EMPTY);
    prev_d     = cur;
    if (eff_empty) begin
      prev_d = (srcshift == 6'd0) ? data : '0;
    end else begin
      prev_d = cur;
    end
    if (ld_src) begin
      if (eff_empty) begin
        shreg_next = srcshift;
        st_next    = (srcshift == 6'd0) ? READY : FIRST;
      end else begin
        case (st)
          FIRST:   st_next = READY;
          READY:   st_next = READY;
          default: st_next = EMPTY;
        endcase
      end
    end else if (src_flush) begin
      st_next = EMPTY;
    end else begin
      st_next = st;
    end
  end

  blit_phrase_reg #(.W(2*PW)) u_cur (
    .clk(sys_clk), .reset(reset), .clr(src_flush), .ld(ld_src), .d(data), .q(cur)
  );
  blit_phrase_reg #(.W(2*PW)) u_prev (
    .clk(sys_clk), .reset(reset), .clr(src_flush), .ld(ld_src), .d(prev_d), .q(prev)
  );
  blit_phrase_reg #(.W(2*PW)) u_dst (
    .clk(sys_clk), .reset(reset), .clr(1'b0), .ld(ld_dst), .d(data), .q(dst)
  );
  blit_phrase_reg #(.W(2*PW)) u_pat (
    .clk(sys_clk), .reset(reset), .clr(1'b0), .ld(ld_pat), .d(data), .q(pat)
  );
  blit_phrase_reg #(.W(2*PW)) u_srcz1 (
    .clk(sys_clk), .reset(reset), .clr(1'b0), .ld(ld_srcz1), .d(data), .q(srcz1)
  );
  blit_phrase_reg #(.W(2*PW)) u_srcz2 (
    .clk(sys_clk), .reset(reset), .clr(1'b0), .ld(ld_srcz2), .d(data), .q(srcz2)
  );

  assign wide       = {cur, prev} >> shreg;
  assign srcd_0     = wide[PW-1:0];
  assign srcd_1     = wide[2*PW-1:PW];
  assign srcd_valid = (st == READY);

  assign dstd_0  = dst[PW-1:0];
  assign dstd_1  = dst[2*PW-1:PW];
  assign patd_0  = pat[PW-1:0];
  assign patd_1  = pat[2*PW-1:PW];
  assign srcz1_0 = srcz1[PW-1:0];
  assign srcz1_1 = srcz1[2*PW-1:PW];
  assign srcz2_0 = srcz2[PW-1:0];
  assign srcz2_1 = srcz2[2*PW-1:PW];

endmodule
